mapper_collector: RTL
=====================

MAPPER_COLLECTOR -- requirements
Module: mapper_collector

Interface
REQ-001 SHALL have parameter NUM_MAPPERS, default 2, number of mapper output streams merged (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of each mapper result word.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_map_valid  input  NUM_MAPPERS  per-mapper result valid.
REQ-006 SHALL have port i_map_data  input  NUM_MAPPERS*DATA_WIDTH  per-mapper result words; mapper k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port i_map_last  input  NUM_MAPPERS  marks the final word of a mapper's job.
REQ-008 SHALL have port o_map_rdy  output  NUM_MAPPERS  per-mapper accept strobe.
REQ-009 SHALL have port o_red_valid  output  1  merged word valid toward reducer.
REQ-010 SHALL have port o_red_data  output  DATA_WIDTH  merged word.
REQ-011 SHALL have port o_red_last  output  1  final word of the whole job (all mappers finished).
REQ-012 SHALL have port i_red_rdy  input  1  reducer ready.
REQ-013 SHALL have port o_word_cnt  output  32  count of words accepted by reducer.

Function
REQ-014 Transfer rules: mapper transfer when i_map_valid[k] && o_map_rdy[k]; reducer transfer when o_red_valid && i_red_rdy.
REQ-015 Output register (o_red_valid/data/last) SHALL be loadable when empty or draining: load_ok = !o_red_valid || i_red_rdy.
REQ-016 Eligible mapper k: i_map_valid[k]=1 and done[k]=0.
REQ-017 Grant: if load_ok, grant the first eligible mapper searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_MAPPERS; at most one grant per cycle.
REQ-018 o_map_rdy SHALL be one-hot on the granted mapper, all zero when no grant or !load_ok; o_map_rdy is combinational from valid/done/rr_ptr/load_ok.
REQ-019 On grant g: output register loads i_map_data slice g next edge, o_red_valid=1; rr_ptr <= (g+1) mod NUM_MAPPERS (wrap from NUM_MAPPERS-1 to 0).
REQ-020 No grant and reducer transfer: o_red_valid <= 0 next edge; no grant and no transfer: register holds (data stable while valid && !i_red_rdy).
REQ-021 On grant g with i_map_last[g]=1: done[g] <= 1; once done, mapper g receives no rdy until job end.
REQ-022 If the grant sets the last outstanding done bit (all others already 1), loaded word SHALL carry o_red_last=1 and all done bits SHALL clear on the same edge (next job starts immediately); otherwise o_red_last=0.
REQ-023 Simultaneous last from several mappers: served one per cycle in round-robin order; only the final one yields o_red_last.
REQ-024 o_word_cnt SHALL increment by 1 per reducer transfer, saturating at 32'hFFFF_FFFF; not cleared by o_red_last.
REQ-025 Latency: mapper transfer to o_red_valid exactly 1 cycle; sustained throughput 1 word/cycle when i_red_rdy=1.
REQ-026 Data SHALL never be dropped or duplicated; per-mapper word order preserved.

Reset
REQ-027 When i_rst_n=0 at a clock edge: o_red_valid=0, o_red_data=0, o_red_last=0, o_word_cnt=0, done=0, rr_ptr=0; o_map_rdy=0 during reset.
REQ-028 Reset mid-transfer SHALL discard the held output word; mappers retain own data (no rdy issued during reset).

Verification
REQ-029 N=2, both valid continuously, i_red_rdy=1, data A0,A1.. / B0,B1.. -> output A0,B0,A1,B1..., one word/cycle, o_word_cnt increments each cycle.
REQ-030 Output stalled (i_red_rdy=0 for 3 cycles with o_red_valid=1) -> o_map_rdy=0, o_red_data stable, o_word_cnt unchanged; resumes without loss.
REQ-031 Mapper0 last on 2nd word, mapper1 sends 4 words last on 4th -> after mapper0 done only mapper1 granted; o_red_last=1 only on mapper1 word 4; next cycle done bits clear.
REQ-032 Both mappers present last same cycle, rr_ptr=1 -> mapper1 word first (o_red_last=0), mapper0 word next with o_red_last=1.
REQ-033 Assert i_rst_n=0 while o_red_valid=1 -> next edge all outputs 0, rr_ptr=0; post-reset first grant goes to mapper0.
REQ-034 Force o_word_cnt near 32'hFFFF_FFFE (preload via long run or force) and send 3 words -> count saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/mapper_collector.sv
// Merges NUM_MAPPERS result streams into a single registered reducer stream.
// Arbitration is round-robin. A job ends once every mapper has delivered its last word.
module mapper_collector #(
  parameter int NUM_MAPPERS = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_MAPPERS-1:0]            i_map_valid,
  input  logic [NUM_MAPPERS*DATA_WIDTH-1:0] i_map_data,
  input  logic [NUM_MAPPERS-1:0]            i_map_last,
  output logic [NUM_MAPPERS-1:0]            o_map_rdy,
  output logic                              o_red_valid,
  output logic [DATA_WIDTH-1:0]             o_red_data,
  output logic                              o_red_last,
  input  logic                              i_red_rdy,
  output logic [31:0]                       o_word_cnt
);

  localparam int PTR_W = $clog2(NUM_MAPPERS);
  typedef logic [PTR_W-1:0] ptr_t;

  logic [NUM_MAPPERS-1:0] done_q, done_d;
  ptr_t                   rr_ptr_q, rr_ptr_d;
  logic                   red_valid_q, red_valid_d;
  logic [DATA_WIDTH-1:0]  red_data_q, red_data_d;
  logic                   red_last_q, red_last_d;
  logic [31:0]            word_cnt_q, word_cnt_d;

  logic [NUM_MAPPERS-1:0] eligible;
  logic [NUM_MAPPERS-1:0] grant_oh;
  logic                   load_ok;
  logic                   grant_vld;
  ptr_t                   grant_idx;
  logic [PTR_W:0]         cand;

  assign load_ok  = !red_valid_q || i_red_rdy;
  assign eligible = i_map_valid & ~done_q;

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_MAPPERS; the first eligible mapper wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_MAPPERS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_MAPPERS)) cand = cand - (PTR_W+1)'(NUM_MAPPERS);
      if (!grant_vld && load_ok && eligible[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    o_map_rdy = '0;
    for (int k = 0; k < NUM_MAPPERS; k++) begin
      grant_oh[k]  = grant_vld && (grant_idx == ptr_t'(k));
      o_map_rdy[k] = grant_oh[k] && i_rst_n;
    end
  end

  always_comb begin
    done_d      = done_q;
    rr_ptr_d    = rr_ptr_q;
    red_valid_d = red_valid_q;
    red_data_d  = red_data_q;
    red_last_d  = red_last_q;
    word_cnt_d  = word_cnt_q;

    if (grant_vld) begin
      red_valid_d = 1'b1;
      red_data_d  = i_map_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      red_last_d  = 1'b0;
      rr_ptr_d    = (grant_idx == ptr_t'(NUM_MAPPERS-1)) ? '0 : grant_idx + ptr_t'(1);
      if (i_map_last[grant_idx]) begin
        // The final outstanding last closes the job and re-arms every mapper at once.
        if (&(done_q | grant_oh)) begin
          red_last_d = 1'b1;
          done_d     = '0;
        end else begin
          done_d     = done_q | grant_oh;
        end
      end
    end else if (i_red_rdy) begin
      red_valid_d = 1'b0;
      red_last_d  = 1'b0;
    end

    if (red_valid_q && i_red_rdy && (word_cnt_q != 32'hFFFF_FFFF))
      word_cnt_d = word_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      done_q      <= '0;
      rr_ptr_q    <= '0;
      red_valid_q <= 1'b0;
      red_data_q  <= '0;
      red_last_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      done_q      <= done_d;
      rr_ptr_q    <= rr_ptr_d;
      red_valid_q <= red_valid_d;
      red_data_q  <= red_data_d;
      red_last_q  <= red_last_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign o_red_valid = red_valid_q;
  assign o_red_data  = red_data_q;
  assign o_red_last  = red_last_q;
  assign o_word_cnt  = word_cnt_q;

endmodule
